// File: rtl/pulse_generator.sv
// pulse_generator: programmable pulse train, N single-cycle pulses per
// CNT_WINDOW-cycle gate window, spread evenly by a modular accumulator.
//
// Ports:
//   clk_in      system clock, rising edge
//   rst_in      synchronous reset, active-high
//   en_in       run enable; low holds the generator idle
//   load_in     one-cycle strobe, captures count_in as the pending count
//   count_in    requested pulses per window (N)
//   pulse_out   registered pulse train
//   window_out  high on the first cycle of each running window
//   count_out   N in effect for the current window
module pulse_generator #(
    parameter int unsigned CNT_WINDOW = 200000000
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       en_in,
    input  logic       load_in,
    input  logic [7:0] count_in,
    output logic       pulse_out,
    output logic       window_out,
    output logic [7:0] count_out
);

    localparam logic [31:0] W_LAST = 32'(CNT_WINDOW - 1);
    localparam logic [32:0] W_33   = 33'(CNT_WINDOW);

    logic [31:0] tim_cnt_q, tim_cnt_d;
    logic [32:0] acc_q, acc_d;
    logic [7:0]  pend_q, pend_d;
    logic [7:0]  active_q, active_d;
    logic        run_q, run_d;
    logic        pulse_q, pulse_d;

    logic        at_start;
    logic        step;
    logic [7:0]  n_eff;
    logic [32:0] sum;
    logic        fire;

    always_comb begin
        at_start = (tim_cnt_q == 32'd0);
        // The run flag arms on the first edge that sees en_in high, so the
        // window starts (index 0) on the cycle where window_out is visible.
        step     = en_in && run_q;
        n_eff    = at_start ? (load_in ? count_in : pend_q) : active_q;
        // The accumulator restarts at each window so it is exactly 0 there.
        sum      = (at_start ? 33'd0 : acc_q) + {25'd0, n_eff};
        fire     = (sum >= W_33);

        pend_d   = load_in ? count_in : pend_q;
        run_d    = en_in;
        active_d = active_q;
        tim_cnt_d = 32'd0;
        acc_d    = 33'd0;
        pulse_d  = 1'b0;

        if (step) begin
            if (at_start) begin
                active_d = n_eff;
            end
            tim_cnt_d = (tim_cnt_q == W_LAST) ? 32'd0 : tim_cnt_q + 32'd1;
            acc_d     = fire ? (sum - W_33) : sum;
            pulse_d   = fire;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tim_cnt_q <= 32'd0;
            acc_q     <= 33'd0;
            pend_q    <= 8'd0;
            active_q  <= 8'd0;
            run_q     <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            tim_cnt_q <= tim_cnt_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            active_q  <= active_d;
            run_q     <= run_d;
            pulse_q   <= pulse_d;
        end
    end

    assign pulse_out  = pulse_q;
    assign window_out = run_q && (tim_cnt_q == 32'd0);
    assign count_out  = active_q;

endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed bench for pulse_generator with W=16 and
// W=256 instances sharing clock and reset.
module tb_pulse_generator;

    logic       clk = 1'b0;
    logic       rst_in = 1'b1;

    logic       en_a = 1'b0, load_a = 1'b0;
    logic [7:0] cnt_in_a = 8'd0;
    logic       pulse_a, window_a;
    logic [7:0] cnt_out_a;

    logic       en_b = 1'b0, load_b = 1'b0;
    logic [7:0] cnt_in_b = 8'd0;
    logic       pulse_b, window_b;
    logic [7:0] cnt_out_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pulse_generator #(.CNT_WINDOW(16)) dut_a (
        .clk_in(clk), .rst_in(rst_in), .en_in(en_a), .load_in(load_a),
        .count_in(cnt_in_a), .pulse_out(pulse_a), .window_out(window_a),
        .count_out(cnt_out_a)
    );

    pulse_generator #(.CNT_WINDOW(256)) dut_b (
        .clk_in(clk), .rst_in(rst_in), .en_in(en_b), .load_in(load_b),
        .count_in(cnt_in_b), .pulse_out(pulse_b), .window_out(window_b),
        .count_out(cnt_out_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles of dut_a starting at window index 0, collecting
    // pulse_out / window_out per index and count_out at index 1.
    task automatic win(input int n, input logic [15:0] exp_p,
                       input logic [7:0] exp_c, input int ld_i,
                       input logic [7:0] ld_v, input string tag);
        logic [15:0] p;
        logic [15:0] w;
        logic [7:0]  c;
        p = '0;
        w = '0;
        c = '0;
        for (int i = 0; i < n; i++) begin
            load_a   = (i == ld_i);
            cnt_in_a = ld_v;
            p[i] = pulse_a;
            w[i] = window_a;
            if (i == 1) c = cnt_out_a;
            tick();
        end
        load_a = 1'b0;
        chk({tag, "_pulse"}, 32'(p), 32'(exp_p));
        chk({tag, "_window"}, 32'(w), 32'h0001);
        chk({tag, "_count"}, 32'(c), 32'(exp_c));
    endtask

    initial begin
        int np;
        int nw;
        logic idx1;

        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_pulse", 32'(pulse_a), 32'd0);
        chk("rst_window", 32'(window_a), 32'd0);
        chk("rst_count", 32'(cnt_out_a), 32'd0);

        // load while idle only sets the pending count
        load_a = 1'b1;
        cnt_in_a = 8'd4;
        tick();
        load_a = 1'b0;
        chk("idle_load_count", 32'(cnt_out_a), 32'd0);

        en_a = 1'b1;
        tick();
        win(16, 16'h1110, 8'd4, -1, 8'd0, "n4_w1");
        win(16, 16'h1111, 8'd4, -1, 8'd0, "n4_w2");
        // mid-window load of 7 does not disturb this window
        win(16, 16'h1111, 8'd4, 5, 8'd7, "n4_midload");
        win(16, 16'h54A9, 8'd7, -1, 8'd0, "n7");
        // load of 0 at index 0 applies to this same window
        win(16, 16'h0001, 8'd0, 0, 8'd0, "n0_w1");
        win(16, 16'h0000, 8'd0, -1, 8'd0, "n0_w2");
        win(16, 16'h0000, 8'd0, 9, 8'd15, "n0_w3");
        win(16, 16'hFFFC, 8'd15, -1, 8'd0, "n15_w1");
        win(16, 16'hFFFD, 8'd15, -1, 8'd0, "n15_w2");
        win(16, 16'h1111, 8'd4, 0, 8'd4, "n4_again");

        // disable at index 10, hold low for 3 cycles
        win(10, 16'h0111, 8'd4, -1, 8'd0, "pre_drop");
        en_a = 1'b0;
        tick();
        chk("drop_pulse", 32'(pulse_a), 32'd0);
        chk("drop_window", 32'(window_a), 32'd0);
        tick();
        tick();
        en_a = 1'b1;
        chk("armed_window", 32'(window_a), 32'd0);
        tick();
        win(16, 16'h1110, 8'd4, -1, 8'd0, "reen_w1");
        win(16, 16'h1111, 8'd4, -1, 8'd0, "reen_w2");

        // reset in the middle of a running window
        win(6, 16'h0011, 8'd4, -1, 8'd0, "pre_rst");
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        chk("mrst_pulse", 32'(pulse_a), 32'd0);
        chk("mrst_window", 32'(window_a), 32'd0);
        chk("mrst_count", 32'(cnt_out_a), 32'd0);
        tick();
        win(16, 16'h0000, 8'd0, -1, 8'd0, "post_rst");

        // W=256, N=255: only index 1 stays low
        load_b = 1'b1;
        cnt_in_b = 8'd255;
        tick();
        load_b = 1'b0;
        en_b = 1'b1;
        tick();
        for (int w = 0; w < 2; w++) begin
            np = 0;
            nw = 0;
            idx1 = 1'b1;
            for (int i = 0; i < 256; i++) begin
                if (pulse_b) np++;
                if (window_b) nw++;
                if (i == 1) idx1 = pulse_b;
                tick();
            end
            chk($sformatf("n255_w%0d_pulses", w), 32'(np),
                (w == 0) ? 32'd254 : 32'd255);
            chk($sformatf("n255_w%0d_idx1", w), 32'(idx1), 32'd0);
            chk($sformatf("n255_w%0d_windows", w), 32'(nw), 32'd1);
        end
        chk("n255_count", 32'(cnt_out_b), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pulse_generator.md
Name: pulse_generator

Overview:
- Synthesises a pulse train with an exact, programmable number of single-cycle pulses per fixed gate window.
- The pulses are spread as evenly as possible across the window.
- This is the stimulus-side counterpart of the gated pulse counter: feeding pulse_out into the counter with the same window length reads back count_in.
- Used as on-board self-test source and as a programmable rate generator for the LED datapath.

Parameters:
CNT_WINDOW, 200000000, gate window length in clk_in cycles (W); legal range 256..2^32-1 so that W > every N.

Ports:
clk_in  input  1  system clock; all logic on rising edge
rst_in  input  1  synchronous reset, active-high
en_in  input  1  run enable; low holds the generator idle
load_in  input  1  one-cycle strobe: capture count_in as the pending count
count_in  input  8  requested pulses per window (N), 0..255
pulse_out  output  1  generated pulse train, single-cycle high pulses, registered
window_out  output  1  high for the first cycle (tim_cnt == 0) of each running window
count_out  output  8  count N in effect for the current window

Behaviour:
- Reset values (rst_in high at a clock edge, overrides everything):
  - tim_cnt = 0, acc = 0, pend = 0, active = 0.
  - pulse_out = 0, window_out = 0, count_out = 0.
- Load path:
  - load_in high: pend <= count_in.
  - active is updated only at a window start. A mid-window load never alters the current window.
- Window timer:
  - While en_in = 1, tim_cnt counts 0..W-1 and wraps to 0.
  - Wrap is exact: a window is W cycles long, with no extra cycle.
- Count selection (N_eff):
  - Cycle with tim_cnt == 0: N_eff = load_in ? count_in : pend, and active <= N_eff. A load coinciding with the window start applies to that window.
  - Other cycles: N_eff = active.
- Distribution (accumulator, 33 bits, never overflows):
  - Each enabled cycle: sum = (tim_cnt == 0 ? 0 : acc) + N_eff.
  - If sum >= W: acc <= sum - W and pulse_out <= 1.
  - Otherwise: acc <= sum and pulse_out <= 0.
- Pulse timing:
  - Decision at index k is visible on pulse_out at index k+1. Latency is one cycle.
  - Exactly N decisions fire per window, at k = ceil(m·W/N) - 1 for m = 1..N.
  - The last decision is at k = W-1, so the Nth pulse appears in cycle 0 of the following window. This is intended.
  - acc is exactly 0 at every boundary.
- Edge values of N:
  - N = 0: pulse_out stays 0 for the whole window. window_out still strobes.
  - Max pulse density is N = 255 with W = 256: pulse on every cycle except one.
- window_out: registered-state decode, equal to en_in_q && tim_cnt == 0, where en_in_q is the registered run flag.
- count_out = active.
- Enable:
  - en_in = 0: next edge forces tim_cnt = 0, acc = 0, pulse_out = 0. Run flag clears, and active/pend hold.
  - en_in low mid-window aborts the window. Any pending pulse is dropped: pulse_out is 0 in the cycle after en_in falls.
  - en_in rising: the first enabled cycle is window index 0. window_out goes high on that cycle and N_eff is captured per the selection rule.
- Reset mid-window: same as power-on reset. pend returns to 0.

Test Plan:
- W=16, load 4, enable -> pulse_out high at window indices 4, 8, 12 and index 0 of next window. window_out every 16 cycles. 4 pulses per 16-cycle span, steady state.
- W=16, N=0 then N=16 illegal-free check with N=15 -> N=0: no pulses for 3 windows. N=15: 15 pulses per window, single gap after decision k=0.
- W=256, N=255 -> pulse_out low only at index 1 of each window, high otherwise. acc back to 0 at each boundary (check via pulse count = 255 per window).
- W=16, N=4 running; load 7 at index 5 -> current window still gives 4 pulses. count_out switches to 7 at next index 0 and that window yields 7. Load coinciding with index 0 takes effect in that same window.
- en_in dropped at index 10 then raised 3 cycles later -> pulse_out 0 from next cycle. First window_out on re-enable cycle. Full N pulses in the new window.
- rst_in asserted mid-window with N=4 -> all outputs 0 next cycle. count_out = 0. After release with en_in=1 and no load, no pulses generated.
